// File: rtl/arb_port_mux.sv
// arb_port_mux: two input FIFOs merged onto one registered output under an external 2-way arbiter
// Ports: i_clk, i_rst_n (async, active-low); per-port i_valid/o_ready/i_data0/i_data1/i_last;
//        o_request/i_grant to the arbiter; o_valid/i_ready/o_data/o_last/o_port on the output.
// Define ARB_PORT_MUX_LOCK_EN to hold the grant on one port until the last beat of its packet.
module arb_port_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_valid,
    output logic [1:0]            o_ready,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [1:0]            i_last,
    output logic [1:0]            o_request,
    input  logic [1:0]            i_grant,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_port
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1;
    logic [EW-1:0] mem_q [2][FIFO_DEPTH];
    logic [1:0][AW:0] wp_q, wp_d, rp_q, rp_d;
    logic [1:0][EW-1:0] din, head;
    logic [1:0] empty, full, push, pop, allow;
    logic out_free, xfer, sel;
    logic o_valid_q, o_valid_d, o_last_q, o_last_d, o_port_q, o_port_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        din[0] = {i_last[0], i_data0};
        din[1] = {i_last[1], i_data1};
        out_free = !o_valid_q || i_ready;
        for (int n = 0; n < 2; n++) begin
            empty[n] = wp_q[n] == rp_q[n];
            full[n] = (wp_q[n][AW] != rp_q[n][AW]) && (wp_q[n][AW-1:0] == rp_q[n][AW-1:0]);
            head[n] = mem_q[n][rp_q[n][AW-1:0]];
            push[n] = i_valid[n] && !full[n];
            o_ready[n] = !full[n];
            o_request[n] = !empty[n] && out_free && allow[n];
        end
    end
    // Kept apart from the request logic so the arbiter's combinational grant forms no loop.
    always_comb begin
        sel = i_grant[1];
        xfer = (i_grant == 2'b01 && o_request[0]) || (i_grant == 2'b10 && o_request[1]);
        for (int n = 0; n < 2; n++) begin
            pop[n] = xfer && i_grant[n];
            wp_d[n] = push[n] ? wp_q[n] + (AW+1)'(1) : wp_q[n];
            rp_d[n] = pop[n] ? rp_q[n] + (AW+1)'(1) : rp_q[n];
        end
        o_valid_d = xfer || (o_valid_q && !i_ready);
        {o_last_d, o_data_d} = xfer ? head[sel] : {o_last_q, o_data_q};
        o_port_d = xfer ? sel : o_port_q;
    end
`ifdef ARB_PORT_MUX_LOCK_EN
    logic lock_q, lock_d, lock_port_q, lock_port_d;
    assign allow = lock_q ? (lock_port_q ? 2'b10 : 2'b01) : 2'b11;
    always_comb begin
        lock_d = xfer ? !head[sel][EW-1] : lock_q;
        lock_port_d = xfer ? sel : lock_port_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end
`else
    assign allow = 2'b11;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
            o_valid_q <= 1'b0;
            o_data_q <= '0;
            o_last_q <= 1'b0;
            o_port_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            o_valid_q <= o_valid_d;
            o_data_q <= o_data_d;
            o_last_q <= o_last_d;
            o_port_q <= o_port_d;
        end
    end
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 2; n++)
            if (push[n]) mem_q[n][wp_q[n][AW-1:0]] <= din[n];
    end
    assign o_valid = o_valid_q;
    assign o_data = o_data_q;
    assign o_last = o_last_q;
    assign o_port = o_port_q;
endmodule

// File: tb/tb_arb_port_mux.sv
// tb_arb_port_mux: table vectors plus per-port scoreboards for arb_port_mux
module tb_arb_port_mux;
    localparam int DW = 32;
    logic i_clk = 1'b0;
    logic i_rst_n;
    logic [1:0] i_valid, o_ready, i_last, o_request, i_grant;
    logic [DW-1:0] i_data0, i_data1, o_data;
    logic o_valid, i_ready, o_last, o_port;

    arb_port_mux #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data0(i_data0), .i_data1(i_data1), .i_last(i_last), .o_request(o_request),
        .i_grant(i_grant), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_last(o_last), .o_port(o_port)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic l; logic [DW-1:0] d; } beat_t;
    typedef struct { logic p; logic [DW-1:0] d; logic l; int lat; } vec_t;

    beat_t dq0[$], dq1[$], sb0[$], sb1[$];
    logic port_log[$];
    int cyc_log[$];
    int errs = 0, checks = 0, cyc = 0, n_out = 0, out_cyc = 0;
    int in_cyc[2], n_acc[2];
    logic [DW-1:0] out_d;
    logic out_p, out_l, prio, ovr_en, hv;
    logic [1:0] ovr_val;
    logic [DW+1:0] hsnap;

    // Round-robin arbiter model: on a tie the port not granted last time wins.
    always_comb i_grant = ovr_en ? ovr_val : (o_request == 2'b11 ? (prio ? 2'b10 : 2'b01) : o_request);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic p, input logic [DW-1:0] d, input logic l);
        if (p) dq1.push_back({l, d});
        else dq0.push_back({l, d});
    endtask

    task automatic cycle();
        logic a0, a1, gv;
        logic [1:0] g;
        beat_t e;
        @(negedge i_clk);
        cyc++;
        a0 = i_valid[0] & o_ready[0];
        a1 = i_valid[1] & o_ready[1];
        if (a0) begin sb0.push_back({i_last[0], i_data0}); in_cyc[0] = cyc; n_acc[0]++; end
        if (a1) begin sb1.push_back({i_last[1], i_data1}); in_cyc[1] = cyc; n_acc[1]++; end
        if (hv) chk("hold", {o_port, o_last, o_data}, hsnap);
        if (o_valid && i_ready) begin
            if ((o_port ? sb1.size() : sb0.size()) == 0) begin
                checks++;
                errs++;
                $display("FAIL out_extra: got beat 0x%0h on port %0d, expected none", o_data, o_port);
            end else begin
                if (o_port) e = sb1.pop_front();
                else e = sb0.pop_front();
                chk("out_beat", {o_last, o_data}, e);
            end
            port_log.push_back(o_port);
            cyc_log.push_back(cyc);
            n_out++;
            out_d = o_data;
            out_p = o_port;
            out_l = o_last;
            out_cyc = cyc;
        end
        hv = o_valid & ~i_ready;
        hsnap = {o_port, o_last, o_data};
        g = i_grant & o_request;
        gv = !ovr_en && (g == 2'b01 || g == 2'b10);
        @(posedge i_clk);
        #1;
        if (gv) prio = g[0];
        if (a0) void'(dq0.pop_front());
        if (a1) void'(dq1.pop_front());
        i_valid[0] = dq0.size() != 0;
        i_valid[1] = dq1.size() != 0;
        if (i_valid[0]) {i_last[0], i_data0} = dq0[0];
        if (i_valid[1]) {i_last[1], i_data1} = dq1[0];
    endtask

    initial begin
        vec_t vt[5];
        int base, gaps;
        logic [1:0] exp037 [6];
        vt[0] = '{1'b0, 32'h0000_00A5, 1'b1, 2};
        vt[1] = '{1'b1, 32'h0000_5A5A, 1'b0, 2};
        vt[2] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 2};
        vt[3] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 2};
        vt[4] = '{1'b0, 32'h0000_0000, 1'b1, 2};
`ifdef ARB_PORT_MUX_LOCK_EN
        exp037 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
`else
        exp037 = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        i_rst_n = 1'b0;
        i_valid = 2'b00;
        i_last = 2'b00;
        i_data0 = '0;
        i_data1 = '0;
        i_ready = 1'b1;
        prio = 1'b1;
        ovr_en = 1'b0;
        ovr_val = 2'b00;
        hv = 1'b0;
        in_cyc = '{0, 0};
        n_acc = '{0, 0};
        #12;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, '0);
        chk("rst_last_port", {o_last, o_port}, 2'b00);
        chk("rst_ready", o_ready, 2'b11);
        chk("rst_request", o_request, 2'b00);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send(vt[i].p, vt[i].d, vt[i].l);
            repeat (5) cycle();
            chk("vec_data", out_d, vt[i].d);
            chk("vec_port", out_p, vt[i].p);
            chk("vec_last", out_l, vt[i].l);
            chk("vec_latency", out_cyc - in_cyc[vt[i].p], vt[i].lat);
        end

        i_ready = 1'b0;
        base = n_acc[1];
        for (int i = 0; i < 6; i++) send(1'b1, 32'h1000 + i, 1'b1);
        repeat (12) cycle();
        chk("fill_accepted", n_acc[1] - base, 5);
        chk("fill_ready", o_ready, 2'b01);
        chk("fill_valid", o_valid, 1'b1);
        chk("fill_head", o_data, 32'h1000);
        base = n_out;
        i_ready = 1'b1;
        repeat (12) cycle();
        chk("fill_drained", n_out - base, 6);
        chk("fill_sb", sb1.size() + dq1.size(), 0);

        prio = 1'b1;
        port_log.delete();
        cyc_log.delete();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 32'h2000 + i, 1'b1);
            send(1'b1, 32'h3000 + i, 1'b1);
        end
        repeat (26) cycle();
        chk("thru_count", port_log.size(), 16);
        gaps = 0;
        for (int i = 0; i < port_log.size() && i < 16; i++) begin
            chk("thru_port", port_log[i], (i % 2 == 0) ? 1'b1 : 1'b0);
            if (i > 0 && cyc_log[i] - cyc_log[i-1] != 1) gaps++;
        end
        chk("thru_gaps", gaps, 0);

        ovr_en = 1'b1;
        ovr_val = 2'b11;
        base = n_out;
        send(1'b0, 32'h4000, 1'b1);
        send(1'b1, 32'h4001, 1'b1);
        repeat (4) cycle();
        chk("g11_valid", o_valid, 1'b0);
        chk("g11_request", o_request, 2'b11);
        chk("g11_out", n_out - base, 0);
        ovr_en = 1'b0;
        repeat (5) cycle();
        chk("g11_after", n_out - base, 2);
        ovr_en = 1'b1;
        ovr_val = 2'b01;
        base = n_out;
        send(1'b1, 32'h4002, 1'b1);
        repeat (4) cycle();
        chk("gnoreq_valid", o_valid, 1'b0);
        chk("gnoreq_request", o_request, 2'b10);
        ovr_en = 1'b0;
        repeat (4) cycle();
        chk("gnoreq_after", n_out - base, 1);

        prio = 1'b0;
        port_log.delete();
        cyc_log.delete();
        send(1'b0, 32'h5000, 1'b0);
        send(1'b0, 32'h5001, 1'b0);
        send(1'b0, 32'h5002, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 32'h6000 + i, 1'b1);
        repeat (12) cycle();
        chk("pkt_count", port_log.size(), 6);
        for (int i = 0; i < port_log.size() && i < 6; i++) chk("pkt_port", port_log[i], exp037[i][0]);

        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 32'h7000 + i, 1'b1);
        repeat (8) cycle();
        chk("rstmid_held", o_valid, 1'b1);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("rstmid_valid", o_valid, 1'b0);
        chk("rstmid_data", o_data, '0);
        chk("rstmid_ready", o_ready, 2'b11);
        chk("rstmid_request", o_request, 2'b00);
        dq0.delete();
        dq1.delete();
        sb0.delete();
        sb1.delete();
        i_valid = 2'b00;
        hv = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        base = n_out;
        repeat (6) cycle();
        chk("rstmid_no_stale", n_out - base, 0);
        send(1'b1, 32'h1234, 1'b1);
        repeat (5) cycle();
        chk("rstmid_after_data", out_d, 32'h1234);
        chk("rstmid_after_count", n_out - base, 1);
        chk("sb_empty", sb0.size() + sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
